// File: rtl/neuron_seq_pkg.sv
// Shared FSM state encoding and width helpers for the spike/weight sequencer.
package neuron_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_UPDATE = 2'd3
  } seq_state_e;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_spike_shifter.sv
// Load/shift register for the latched spike vector; bit 0 gates the weight slot
// currently being registered, and the register shifts once per consumed slot.
module seq_spike_shifter #(
  parameter int N = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] spikes_i,
  input  logic         shift_i,
  output logic         gate_o
);

  logic [N-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = spikes_i;
    end else if (shift_i) begin
      sr_d = {1'b0, sr_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign gate_o = sr_q[0];

endmodule

// File: rtl/spike_weight_sequencer.sv
// Streams N spike-gated weights per timestep into the neuron accumulator, then
// pulses updateEnable/done. Define SPIKE_COUNT_EN to add the spikeCount output.
module spike_weight_sequencer
  import neuron_seq_pkg::*;
#(
  parameter int INTEGER_WIDTH   = 16,
  parameter int DATA_WIDTH_FRAC = 0,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int num_input       = 31,
  parameter int ADDR_WIDTH      = addr_width(num_input),
  parameter int UPDATE_DELAY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // start is taken only in a cycle where ready=1; start while busy is dropped.
  input  logic                  start,
  input  logic [num_input-1:0]  spikeIn,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] weightAddr,
  output logic                  weightRdEn,
  input  logic [DATA_WIDTH-1:0] weightRdata,
  output logic [DATA_WIDTH-1:0] weightData,
  output logic                  weightValid,
  output logic                  updateEnable,
  output logic                  done,
  output logic [1:0]            stateDbg
`ifdef SPIKE_COUNT_EN
  ,
  output logic [count_width(num_input)-1:0] spikeCount
`endif
);

  localparam int DRAIN_W = $clog2(UPDATE_DELAY + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(num_input - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(UPDATE_DELAY);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  load;
  logic                  slot_q;
  logic                  gate;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wvalid_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          load    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_UPDATE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  // slot_q marks the cycle in which weightRdata carries a requested word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= 1'b0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      slot_q   <= (state_q == ST_FETCH);
      wvalid_q <= slot_q;
      wdata_q  <= (slot_q && gate) ? weightRdata : '0;
    end
  end

  seq_spike_shifter #(
    .N(num_input)
  ) u_shifter (
    .clk     (clk),
    .rst     (reset),
    .load_i  (load),
    .spikes_i(spikeIn),
    .shift_i (slot_q),
    .gate_o  (gate)
  );

  assign ready        = (state_q == ST_IDLE);
  assign weightAddr   = addr_q;
  assign weightRdEn   = (state_q == ST_FETCH);
  assign weightData   = wdata_q;
  assign weightValid  = wvalid_q;
  assign updateEnable = (state_q == ST_UPDATE);
  assign done         = (state_q == ST_UPDATE);
  assign stateDbg     = state_q;

`ifdef SPIKE_COUNT_EN
  localparam int CNT_WIDTH = count_width(num_input);

  logic [CNT_WIDTH-1:0] run_cnt_q;
  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      if (load) begin
        run_cnt_q <= '0;
      end else if (slot_q && gate) begin
        run_cnt_q <= run_cnt_q + CNT_WIDTH'(1);
      end
      if (state_q == ST_UPDATE) begin
        count_q <= run_cnt_q;
      end
    end
  end

  assign spikeCount = count_q;
`endif

endmodule
